// File: rtl/bp_fpga_host_nbf_rx.sv
// NBF receiver: assembles UART bytes (opcode, addr LSB-first, data LSB-first) into packets queued in a circular buffer.
// Latency: packet visible on nbf_v_o the cycle after its last byte; error/overflow/timeout pulses are registered (1 cycle).
// Backpressure: none toward the UART; a packet completing into a full buffer without a same-cycle yumi is dropped. Optional timeout: BP_FPGA_HOST_NBF_RX_TIMEOUT_EN.
module bp_fpga_host_nbf_rx #(
    parameter int nbf_addr_width_p   = 40,
    parameter int nbf_data_width_p   = 64,
    parameter int nbf_opcode_width_p = 8,
    parameter int buffer_els_p       = 4,
    parameter int timeout_cycles_p   = 1000000
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          rx_v_i,
    input  logic [7:0]                    rx_data_i,
    input  logic                          rx_error_i,
    output logic [nbf_opcode_width_p-1:0] nbf_opcode_o,
    output logic [nbf_addr_width_p-1:0]   nbf_addr_o,
    output logic [nbf_data_width_p-1:0]   nbf_data_o,
    output logic                          nbf_v_o,
    input  logic                          nbf_yumi_i,
    output logic                          rx_error_o,
    output logic                          overflow_o,
    output logic                          timeout_o,
    output logic                          busy_o
);
    localparam int addr_bytes_lp = (nbf_addr_width_p + 7) / 8;
    localparam int data_bytes_lp = nbf_data_width_p / 8;
    localparam int max_bytes_lp  = (addr_bytes_lp > data_bytes_lp) ? addr_bytes_lp : data_bytes_lp;
    localparam int cnt_w_lp      = $clog2(max_bytes_lp + 1);
    localparam int pkt_w_lp      = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p;
    localparam int ptr_w_lp      = $clog2(buffer_els_p);
    localparam int occ_w_lp      = $clog2(buffer_els_p + 1);

    localparam logic [1:0] e_opcode = 2'd0;
    localparam logic [1:0] e_addr   = 2'd1;
    localparam logic [1:0] e_data   = 2'd2;

    logic [1:0]                   state_r;
    logic [cnt_w_lp-1:0]          cnt_r;
    logic [7:0]                   opcode_r;
    logic [addr_bytes_lp*8-1:0]   addr_r, addr_n;
    logic [nbf_data_width_p-1:0]  data_r, data_n;
    logic                         byte_v, last_addr, last_data, commit, timeout_fire;
    logic                         rx_error_r, overflow_r;

    logic [pkt_w_lp-1:0]          mem_r [buffer_els_p];
    logic [ptr_w_lp-1:0]          wr_ptr_r, rd_ptr_r;
    logic [occ_w_lp-1:0]          occ_r;
    logic                         full, empty, push, pop;
    logic [pkt_w_lp-1:0]          pkt_in, head;

    // A byte that arrives together with a line error is thrown away with the packet.
    assign byte_v    = rx_v_i & ~rx_error_i;
    assign last_addr = (cnt_r == cnt_w_lp'(addr_bytes_lp - 1));
    assign last_data = (cnt_r == cnt_w_lp'(data_bytes_lp - 1));
    assign commit    = byte_v && (state_r == e_data) && last_data;

    always_comb begin
        addr_n = addr_r;
        data_n = data_r;
        for (int i = 0; i < addr_bytes_lp; i++)
            if (cnt_r == cnt_w_lp'(i)) addr_n[i*8 +: 8] = rx_data_i;
        for (int i = 0; i < data_bytes_lp; i++)
            if (cnt_r == cnt_w_lp'(i)) data_n[i*8 +: 8] = rx_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= e_opcode;
            cnt_r      <= '0;
            rx_error_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            rx_error_r <= rx_error_i;
            overflow_r <= commit & full & ~nbf_yumi_i;
            if (rx_error_i) begin
                state_r <= e_opcode;
                cnt_r   <= '0;
            end else if (byte_v) begin
                case (state_r)
                    e_opcode: begin
                        state_r <= e_addr;
                        cnt_r   <= '0;
                    end
                    e_addr: begin
                        state_r <= last_addr ? e_data : e_addr;
                        cnt_r   <= last_addr ? '0 : cnt_r + cnt_w_lp'(1);
                    end
                    e_data: begin
                        state_r <= last_data ? e_opcode : e_data;
                        cnt_r   <= last_data ? '0 : cnt_r + cnt_w_lp'(1);
                    end
                    default: begin
                        state_r <= e_opcode;
                        cnt_r   <= '0;
                    end
                endcase
            end else if (timeout_fire) begin
                state_r <= e_opcode;
                cnt_r   <= '0;
            end
        end
    end

    // Every byte slot is rewritten each packet, so the assembly registers need no clearing.
    always_ff @(posedge clk_i) begin
        if (byte_v) begin
            if (state_r == e_opcode) opcode_r <= rx_data_i;
            if (state_r == e_addr)   addr_r   <= addr_n;
            if (state_r == e_data)   data_r   <= data_n;
        end
    end

`ifdef BP_FPGA_HOST_NBF_RX_TIMEOUT_EN
    localparam int idle_w_lp = $clog2(timeout_cycles_p + 1);
    logic [idle_w_lp-1:0] idle_r;
    logic                 timeout_r;

    // Fires on the idle cycle that brings the idle count up to timeout_cycles_p.
    assign timeout_fire = (state_r != e_opcode) && !rx_v_i && !rx_error_i &&
                          (idle_r == idle_w_lp'(timeout_cycles_p - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idle_r    <= '0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_fire;
            if (byte_v || rx_error_i || timeout_fire || (state_r == e_opcode))
                idle_r <= '0;
            else
                idle_r <= idle_r + idle_w_lp'(1);
        end
    end
    assign timeout_o = timeout_r;
`else
    assign timeout_fire = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    assign full   = (occ_r == occ_w_lp'(buffer_els_p));
    assign empty  = (occ_r == '0);
    assign pop    = nbf_yumi_i & ~empty;
    // When full, a same-cycle yumi frees the head slot, which the new packet overwrites.
    assign push   = commit & (~full | nbf_yumi_i);
    assign pkt_in = {opcode_r[nbf_opcode_width_p-1:0], addr_r[nbf_addr_width_p-1:0], data_n};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            if (push)
                wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(buffer_els_p - 1)) ? '0 : wr_ptr_r + ptr_w_lp'(1);
            if (pop)
                rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(buffer_els_p - 1)) ? '0 : rd_ptr_r + ptr_w_lp'(1);
            case ({push, pop})
                2'b10:   occ_r <= occ_r + occ_w_lp'(1);
                2'b01:   occ_r <= occ_r - occ_w_lp'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_r[wr_ptr_r] <= pkt_in;
    end

    assign head = empty ? '0 : mem_r[rd_ptr_r];
    assign {nbf_opcode_o, nbf_addr_o, nbf_data_o} = head;
    assign nbf_v_o    = ~empty;
    assign rx_error_o = rx_error_r;
    assign overflow_o = overflow_r;
    assign busy_o     = (state_r != e_opcode);
endmodule
